// File: rtl/jtpang_objdma.sv
// Object-RAM DMA: on a dma_go edge, take the Z80 bus and copy LEN bytes into the object buffer.
// Optional JTPANG_DMA_VBLANK_EN: hold new transfers until vertical blank (LVBL low).
module jtpang_objdma #(
  parameter int            AW       = 12,
  parameter int            LEN      = 512,
  parameter int            BW       = 9,
  parameter logic [AW-1:0] SRC_BASE = 12'h000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          dma_go,
  input  logic          LVBL,
  input  logic          busak_n,
  output logic          busrq,
  output logic [AW-1:0] src_addr,
  output logic          src_rd,
  input  logic [7:0]    src_din,
  output logic [BW-1:0] buf_addr,
  output logic [7:0]    buf_dout,
  output logic          buf_we,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, REQ, RD, WR, REL} state_t;

  localparam logic [BW:0] LAST = (BW+1)'(LEN-1);

  state_t        state, state_nx;
  logic [BW:0]   cnt, cnt_nx, cnt_inc;
  logic          pend, pend_nx, go_last, go_last_nx, go_edge, gate;
  logic          busrq_nx, src_rd_nx, busy_nx, done_nx;
  logic [AW-1:0] src_addr_nx;
  logic [BW-1:0] buf_addr_nx;
  logic [7:0]    buf_dout_nx;

`ifdef JTPANG_DMA_VBLANK_EN
  assign gate = ~LVBL;
`else
  logic unused_lvbl;
  assign unused_lvbl = LVBL;
  assign gate        = 1'b1;
`endif

  assign go_edge = dma_go & ~go_last;
  assign cnt_inc = cnt + (BW+1)'(1);
  // The write strobe lives only in the cen slot of WR, so reset kills it at once
  assign buf_we  = cen & (state == WR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pend     <= 1'b0;
      go_last  <= 1'b0;
      busrq    <= 1'b0;
      src_addr <= SRC_BASE;
      src_rd   <= 1'b0;
      buf_addr <= '0;
      buf_dout <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      pend     <= pend_nx;
      go_last  <= go_last_nx;
      busrq    <= busrq_nx;
      src_addr <= src_addr_nx;
      src_rd   <= src_rd_nx;
      buf_addr <= buf_addr_nx;
      buf_dout <= buf_dout_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    pend_nx     = pend;
    go_last_nx  = go_last;
    busrq_nx    = busrq;
    src_addr_nx = src_addr;
    src_rd_nx   = src_rd;
    buf_addr_nx = buf_addr;
    buf_dout_nx = buf_dout;
    busy_nx     = busy;
    done_nx     = 1'b0;
    if (cen) begin
      go_last_nx = dma_go;
      // Edge is queued first; an IDLE start in the same slot consumes it
      if (go_edge) pend_nx = 1'b1;
      case (state)
        IDLE: if ((pend || go_edge) && gate) begin
          pend_nx  = 1'b0;
          cnt_nx   = '0;
          busy_nx  = 1'b1;
          busrq_nx = 1'b1;
          state_nx = REQ;
        end
        REQ: if (!busak_n) begin
          src_addr_nx = SRC_BASE + AW'(cnt);
          src_rd_nx   = 1'b1;
          state_nx    = RD;
        end
        RD: begin
          src_rd_nx   = 1'b0;
          buf_addr_nx = cnt[BW-1:0];
          buf_dout_nx = src_din;
          state_nx    = WR;
        end
        WR: if (cnt == LAST) begin
          busrq_nx = 1'b0;
          state_nx = REL;
        end else begin
          cnt_nx      = cnt_inc;
          src_addr_nx = SRC_BASE + AW'(cnt_inc);
          src_rd_nx   = 1'b1;
          state_nx    = RD;
        end
        REL: if (busak_n) begin
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtpang_objdma.sv
// Directed bench for jtpang_objdma: basic copy, grant delay, re-trigger, reset mid-copy, address wrap, LVBL gating.
module tb_jtpang_objdma;

  logic        clk = 1'b0, cen = 1'b0, rst_n = 1'b0;
  logic        dma_go = 1'b0, LVBL = 1'b0, busak_n = 1'b1;
  logic        busrq, src_rd, buf_we, busy, done;
  logic [11:0] src_addr;
  logic [7:0]  src_din, buf_dout;
  logic [8:0]  buf_addr;
  logic        busrq_w, src_rd_w, buf_we_w, busy_w, done_w;
  logic [11:0] src_addr_w;
  logic [7:0]  src_din_w, buf_dout_w;
  logic [8:0]  buf_addr_w;

  logic [7:0]  ram [4096];
  logic [16:0] wq[$];
  logic [11:0] wqw[$];
  int          n_chk = 0, n_err = 0;
  int          rd_cnt = 0, done_cnt = 0, bad_we = 0, ph = 0;
  logic        prev_rd = 1'b0, prev_rd_w = 1'b0;

  assign src_din   = ram[src_addr];
  assign src_din_w = ram[src_addr_w];

  jtpang_objdma dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(dma_go), .LVBL(LVBL), .busak_n(busak_n),
    .busrq(busrq), .src_addr(src_addr), .src_rd(src_rd), .src_din(src_din),
    .buf_addr(buf_addr), .buf_dout(buf_dout), .buf_we(buf_we), .busy(busy), .done(done));

  jtpang_objdma #(.SRC_BASE(12'hF00)) dut_w (
    .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(dma_go), .LVBL(LVBL), .busak_n(busak_n),
    .busrq(busrq_w), .src_addr(src_addr_w), .src_rd(src_rd_w), .src_din(src_din_w),
    .buf_addr(buf_addr_w), .buf_dout(buf_dout_w), .buf_we(buf_we_w), .busy(busy_w), .done(done_w));

  // cen is one clk in three and moves 2ns after the rising edge
  always begin
    #5 clk = 1'b1;
    #2 ph = (ph == 2) ? 0 : ph + 1;
    cen = (ph == 2);
    #3 clk = 1'b0;
  end

  always @(negedge clk) begin
    if (buf_we) wq.push_back({buf_addr, buf_dout});
    if (buf_we && !cen) bad_we++;
    if (src_rd && !prev_rd) rd_cnt++;
    if (src_rd_w && !prev_rd_w) wqw.push_back(src_addr_w);
    if (done) done_cnt++;
    prev_rd   = src_rd;
    prev_rd_w = src_rd_w;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    do @(posedge clk); while (!cen);
    #1;
  endtask

  task automatic check_copy(input string tag);
    int bad = 0;
    for (int i = 0; i < wq.size(); i++)
      if (wq[i] !== {9'(i), 8'(i)}) bad++;
    chk({tag, "_len"}, wq.size(), 512);
    chk({tag, "_data"}, bad, 0);
    wq.delete();
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int t = 0;
    while (wq.size() < n && t < 3000) begin tick(); t++; end
    if (t >= 3000) chk({tag, "_wait"}, wq.size(), n);
  endtask

  task automatic finish_copy(input string tag);
    int t = 0;
    while (busrq && t < 3000) begin tick(); t++; end
    chk({tag, "_busrq_drop"}, busrq, 0);
    check_copy(tag);
    busak_n = 1'b1;
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_low"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, "_done_1clk"}, done, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_busrq", busrq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", buf_we, 0);
    chk("rst_rd", src_rd, 0);
    chk("rst_done", done, 0);
    chk("rst_src", src_addr, 12'h000);
    chk("rst_src_w", src_addr_w, 12'hF00);
    chk("rst_buf", buf_addr, 0);

    // Basic copy, with the wrapped-base instance running alongside
    rst_n = 1'b1;
    tick();
    wq.delete(); wqw.delete(); rd_cnt = 0;
    dma_go = 1'b1;
    tick();
    chk("basic_busrq", busrq, 1);
    chk("basic_busy", busy, 1);
    dma_go = 1'b0;
    repeat (2) tick();
    busak_n = 1'b0;
    finish_copy("basic");
    chk("basic_rd", rd_cnt, 512);
    begin
      int bad = 0;
      for (int i = 0; i < wqw.size(); i++)
        if (wqw[i] !== 12'(12'hF00 + i)) bad++;
      chk("wrap_len", wqw.size(), 512);
      chk("wrap_addr", bad, 0);
    end

    // Grant held off for 100 ticks
    rd_cnt = 0;
    dma_go = 1'b1;
    tick();
    chk("grant_busrq", busrq, 1);
    dma_go = 1'b0;
    repeat (100) tick();
    chk("grant_no_we", wq.size(), 0);
    chk("grant_no_rd", rd_cnt, 0);
    busak_n = 1'b0;
    finish_copy("grant");

    // Re-trigger at byte 200, plus a third edge that must be dropped
    dma_go = 1'b1;
    tick();
    dma_go = 1'b0;
    busak_n = 1'b0;
    wait_bytes(200, "rt");
    for (int k = 0; k < 2; k++) begin
      dma_go = 1'b1; tick();
      dma_go = 1'b0; tick();
    end
    finish_copy("rt1");
    tick();
    chk("rt_rearm", busrq, 1);
    busak_n = 1'b0;
    tick();
    finish_copy("rt2");
    repeat (20) tick();
    chk("rt_only_two", busrq, 0);
    chk("rt_idle_busy", busy, 0);

    // Reset mid-copy at byte 37
    dma_go = 1'b1;
    tick();
    dma_go = 1'b0;
    busak_n = 1'b0;
    wait_bytes(37, "rst");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_busrq", busrq, 0);
    chk("rstmid_we", buf_we, 0);
    chk("rstmid_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    busak_n = 1'b1;
    wq.delete();
    repeat (50) tick();
    chk("rstmid_quiet", wq.size(), 0);
    chk("rstmid_norq", busrq, 0);

    // Trigger during active video
    LVBL = 1'b1;
    dma_go = 1'b1;
    tick();
    dma_go = 1'b0;
`ifdef JTPANG_DMA_VBLANK_EN
    repeat (5) tick();
    chk("vb_held", busrq, 0);
    LVBL = 1'b0;
    tick();
    chk("vb_busrq", busrq, 1);
    busak_n = 1'b0;
    wait_bytes(10, "vb");
    LVBL = 1'b1;
`else
    chk("vb_busrq", busrq, 1);
    busak_n = 1'b0;
`endif
    finish_copy("vb");
    LVBL = 1'b0;

    chk("we_in_cen", bad_we, 0);
    chk("done_total", done_cnt, 5);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
